// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with flush, stall and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready no longer depends on out_ready.
module pipe_stage_buf #(
   parameter int DATA_W      = 64,
   parameter int ZERO_BUBBLE = 1,
   parameter int CNT_W       = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              stall,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam bit ZB = (ZERO_BUBBLE != 0);

   state_t            state;
   logic [DATA_W-1:0] main_data;
   logic              acc;
   logic              dq;
`ifdef PIPE_STAGE_SKID_EN
   logic [DATA_W-1:0] skid_data;
`endif

   assign out_valid = (state != EMPTY);
   assign out_data  = main_data;
   assign occupancy = {state == TWO, state == ONE};

`ifdef PIPE_STAGE_SKID_EN
   assign in_ready = ~reset & ~stall & (state != TWO);
`else
   assign in_ready = ~reset & ~stall & (~out_valid | out_ready);
`endif

   assign acc = in_valid & in_ready;
   assign dq  = out_valid & out_ready;

   // Flush outranks any transfer in the same cycle; invalidated payloads are zeroed when ZB is set.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= EMPTY;
         main_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
         skid_data <= '0;
`endif
      end else if (flush) begin
         state <= EMPTY;
         if (ZB) begin
            main_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_data <= '0;
`endif
         end
      end else begin
         case (state)
            EMPTY: begin
               if (acc) begin
                  state     <= ONE;
                  main_data <= in_data;
               end
            end
            ONE: begin
               if (acc && dq) begin
                  main_data <= in_data;
               end else if (dq) begin
                  state <= EMPTY;
                  if (ZB) main_data <= '0;
               end
`ifdef PIPE_STAGE_SKID_EN
               else if (acc) begin
                  state     <= TWO;
                  skid_data <= in_data;
               end
`endif
            end
`ifdef PIPE_STAGE_SKID_EN
            TWO: begin
               if (dq) begin
                  state     <= ONE;
                  main_data <= skid_data;
                  if (ZB) skid_data <= '0;
               end
            end
`endif
            default: state <= EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus a randomized run
// checked against a queue-based model of the stage.
module tb_pipe_stage_buf;

   localparam int DATA_W = 64;
   localparam int CNT_W  = 4;
   localparam int SAT    = 15;
`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic              clock;
   logic              reset;
   logic              flush;
   logic              stall;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [DATA_W-1:0] q[$];
   int                m_cnt = 0;

   pipe_stage_buf #(.DATA_W(DATA_W), .ZERO_BUBBLE(1), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // The model treats the stage as a FIFO of capacity CAP; the head is what downstream sees.
   function automatic logic m_in_ready();
      if (reset || stall) return 1'b0;
      if (CAP == 2) return q.size() < 2;
      return (q.size() == 0) || out_ready;
   endfunction

   function automatic logic m_out_valid();
      return q.size() != 0;
   endfunction

   function automatic logic [DATA_W-1:0] m_out_data();
      if (q.size() != 0) return q[0];
      return '0;
   endfunction

   function automatic logic [1:0] m_occ();
      return 2'(q.size());
   endfunction

   task automatic advance();
      logic acc, dq;
      acc = in_valid && m_in_ready();
      dq  = m_out_valid() && out_ready;
      if (reset) begin
         q.delete();
         m_cnt = 0;
      end else begin
         if (in_valid && !m_in_ready() && m_cnt < SAT) m_cnt++;
         if (flush) q.delete();
         else begin
            if (dq) void'(q.pop_front());
            if (acc) q.push_back(in_data);
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; stall = 0; in_valid = 0; out_ready = 0; in_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      advance();
      reset = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      in_valid = 1;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
      advance();
      advance();
      in_valid = 0;
      reset = 0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0 || stall_cnt !== '0) begin
         n_err++;
         $display("[TB] FAIL reset_state: got v=%b d=%h occ=%0d cnt=%0d expected all 0", out_valid, out_data, occupancy, stall_cnt);
      end
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_stream();
      do_reset();
      in_valid = 1; out_ready = 1;
      for (int i = 1; i <= 8; i++) begin
         in_data = DATA_W'(i);
         #1;
         n_vec++;
         if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", i, in_ready); end
         if (i > 1) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(i - 1)) begin
               n_err++;
               $display("[TB] FAIL stream_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, DATA_W'(i - 1));
            end
         end
         advance();
      end
      in_valid = 0;
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 64'h8) begin n_err++; $display("[TB] FAIL stream_last: got v=%b d=%h expected v=1 d=8", out_valid, out_data); end
      advance();
      n_vec++;
      if (out_valid !== 1'b0 || stall_cnt !== '0) begin n_err++; $display("[TB] FAIL stream_end: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, stall_cnt); end
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] offer[3];
      logic [DATA_W-1:0] seen[$];
      offer[0] = 64'hA; offer[1] = 64'hB; offer[2] = 64'hC;
      do_reset();
      in_valid = 1;
      for (int i = 0; i < 3; i++) begin
         in_data = offer[i];
         #1;
         n_vec++;
         if (in_ready !== (i < CAP)) begin n_err++; $display("[TB] FAIL bp_ready[%0d]: got %b expected %b", i, in_ready, i < CAP); end
         if (in_ready) advance();
         else break;
      end
      n_vec++;
      if (occupancy !== 2'(CAP)) begin n_err++; $display("[TB] FAIL bp_occupancy: got %0d expected %0d", occupancy, CAP); end
      // Release backpressure and keep offering until everything has been delivered.
      out_ready = 1;
      for (int k = 0; k < 8 && seen.size() < 3; k++) begin
         in_valid = (q.size() + seen.size() < 3);
         in_data  = offer[q.size() + seen.size() < 3 ? q.size() + seen.size() : 2];
         #1;
         if (out_valid) seen.push_back(out_data);
         advance();
      end
      in_valid = 0;
      n_vec++;
      if (seen.size() != 3) begin
         n_err++; $display("[TB] FAIL bp_count: got %0d expected 3", seen.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (seen[i] !== offer[i]) begin n_err++; $display("[TB] FAIL bp_order[%0d]: got %h expected %h", i, seen[i], offer[i]); end
         end
      end
   endtask

   task automatic test_flush();
      do_reset();
      in_valid = 1; in_data = 64'h5;
      advance();
      flush = 1; in_data = 64'h6;
      #1;
      advance();
      flush = 0; in_valid = 0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0) begin
         n_err++; $display("[TB] FAIL flush_state: got v=%b occ=%0d d=%h expected 0/0/0", out_valid, occupancy, out_data);
      end
      n_vec++;
      if (stall_cnt !== CNT_W'(m_cnt)) begin n_err++; $display("[TB] FAIL flush_cnt: got %0d expected %0d", stall_cnt, m_cnt); end
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         advance();
         n_vec++;
         if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL flush_ghost[%0d]: got v=%b d=%h expected v=0", i, out_valid, out_data); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      in_valid = 1; in_data = 64'h7;
      advance();
      stall = 1; in_data = 64'h8; out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_vec++;
         if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL stall_ready[%0d]: got %b expected 0", i, in_ready); end
         n_vec++;
         if (out_valid !== (i == 0) || (i == 0 && out_data !== 64'h7)) begin
            n_err++; $display("[TB] FAIL stall_drain[%0d]: got v=%b d=%h expected v=%b", i, out_valid, out_data, i == 0);
         end
         advance();
      end
      stall = 0; in_valid = 0;
      #1;
      n_vec++;
      if (stall_cnt !== CNT_W'(3) || out_valid !== 1'b0) begin
         n_err++; $display("[TB] FAIL stall_cnt: got cnt=%0d v=%b expected cnt=3 v=0", stall_cnt, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 1;
      for (int i = 0; i < CAP; i++) begin
         in_data = DATA_W'(64'hD0 + i);
         advance();
      end
      n_vec++;
      if (occupancy !== 2'(CAP)) begin n_err++; $display("[TB] FAIL rmid_fill: got %0d expected %0d", occupancy, CAP); end
      reset = 1; out_ready = 1;
      advance();
      reset = 0; in_valid = 0; out_ready = 0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0 || stall_cnt !== '0) begin
         n_err++; $display("[TB] FAIL rmid_clear: got v=%b d=%h occ=%0d cnt=%0d expected all 0", out_valid, out_data, occupancy, stall_cnt);
      end
      in_valid = 1; in_data = 64'h9; out_ready = 1;
      advance();
      in_valid = 0;
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 64'h9) begin n_err++; $display("[TB] FAIL rmid_first: got v=%b d=%h expected v=1 d=9", out_valid, out_data); end
      advance();
   endtask

   task automatic test_saturate();
      do_reset();
      stall = 1; in_valid = 1;
      for (int i = 0; i < 20; i++) advance();
      stall = 0; in_valid = 0;
      #1;
      n_vec++;
      if (stall_cnt !== CNT_W'(SAT)) begin n_err++; $display("[TB] FAIL sat_cnt: got %0d expected %0d", stall_cnt, SAT); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         reset     = ($urandom_range(0, 99) < 1);
         flush     = ($urandom_range(0, 99) < 5);
         stall     = ($urandom_range(0, 99) < 20);
         in_valid  = ($urandom_range(0, 99) < 70);
         out_ready = ($urandom_range(0, 99) < 60);
         in_data   = {$urandom, $urandom};
         #1;
         n_vec++;
         if (in_ready !== m_in_ready()) begin n_err++; $display("[TB] FAIL rnd_in_ready[%0d]: got %b expected %b", i, in_ready, m_in_ready()); end
         n_vec++;
         if (out_valid !== m_out_valid()) begin n_err++; $display("[TB] FAIL rnd_out_valid[%0d]: got %b expected %b", i, out_valid, m_out_valid()); end
         n_vec++;
         if (out_data !== m_out_data()) begin n_err++; $display("[TB] FAIL rnd_out_data[%0d]: got %h expected %h", i, out_data, m_out_data()); end
         n_vec++;
         if (occupancy !== m_occ()) begin n_err++; $display("[TB] FAIL rnd_occupancy[%0d]: got %0d expected %0d", i, occupancy, m_occ()); end
         n_vec++;
         if (stall_cnt !== CNT_W'(m_cnt)) begin n_err++; $display("[TB] FAIL rnd_stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt, m_cnt); end
         advance();
      end
      reset = 0;
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_stall();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
